muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit for the MIPS datapath. It owns the architectural HI/LO registers and replaces the single-cycle combinational MULT/DIV paths of the ALU.
- Iterative: one radix-2 step per clock, signed and unsigned, with a start/busy/done handshake.
- The decode/hazard logic stalls on `busy` whenever it sees MFHI/MFLO or a new mul/div.

---
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Optional MADD/MSUB accumulate ops are enabled by defining MULDIV_ACC_EN.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned DW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_ACC_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    part_q, part_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             acc_op, mul_op, div_op, sgn_op, a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic             run_div;
    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub, div_rem;
    logic [DW-1:0]    div_next;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Request decode and operand magnitudes
    always_comb begin
`ifdef MULDIV_ACC_EN
        acc_op = (op == OP_MADD) || (op == OP_MSUB);
`else
        acc_op = 1'b0;
`endif
        mul_op = (op == OP_MULT) || (op == OP_MULTU) || acc_op;
        div_op = (op == OP_DIV) || (op == OP_DIVU);
        sgn_op = (op == OP_MULT) || (op == OP_DIV) || acc_op;
        a_neg  = sgn_op & a[WIDTH-1];
        b_neg  = sgn_op & b[WIDTH-1];
        abs_a  = a_neg ? (~a + WIDTH'(1)) : a;
        abs_b  = b_neg ? (~b + WIDTH'(1)) : b;
    end

    // One shift-add (multiply) or restoring (divide) step on part_q
    always_comb begin
        run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
        mul_sum   = {1'b0, part_q[DW-1:WIDTH]} + (part_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, part_q[WIDTH-1:1]};
        div_shift = part_q[DW-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
        div_next  = {div_rem, part_q[WIDTH-2:0], div_ge};
    end

    // Sign correction of the finished magnitudes; b==0 forces an all-ones quotient
    always_comb begin
        prod_fix = neg_q ? (~part_q + DW'(1)) : part_q;
        if (opnd_q == '0) begin
            quo_fix = '1;
        end else begin
            quo_fix = neg_q ? (~part_q[WIDTH-1:0] + WIDTH'(1)) : part_q[WIDTH-1:0];
        end
        rem_fix = rneg_q ? (~part_q[DW-1:WIDTH] + WIDTH'(1)) : part_q[DW-1:WIDTH];
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        opnd_d  = opnd_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mul_op || div_op) begin
                        part_d  = div_op ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        opnd_d  = div_op ? abs_b : abs_a;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        op_d    = op;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                        if (div_op) begin
                            dz_d = 1'b0;
                        end
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                part_d = run_div ? div_next : mul_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                case (op_q)
                    OP_MULT, OP_MULTU: {hi_d, lo_d} = prod_fix;
                    OP_DIV, OP_DIVU: begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                        dz_d = (opnd_q == '0);
                    end
`ifdef MULDIV_ACC_EN
                    OP_MADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_fix;
                    OP_MSUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_fix;
`endif
                    default: ;
                endcase
                cnt_d   = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            opnd_q  <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            opnd_q  <= opnd_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/div_zero,
// a negedge monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MSUB  = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        string       nm;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            check("done_expected", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.nm, "_hilo"}, {hi, lo}, {e.hi, e.lo});
                check({e.nm, "_div_zero"}, 64'(div_zero), 64'(e.dz));
            end
        end
    end

    // Issue one iterative op; ign_at>0 pulses an extra start that must be ignored
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input logic edz,
                          input string nm, input int ign_at);
        exp_t e;
        int   lat;
        e.hi = eh; e.lo = el; e.dz = edz; e.nm = nm;
        sb_q.push_back(e);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        check({nm, "_busy"}, 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ign_at > 0 && lat == ign_at) begin
                start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        check({nm, "_latency"}, 64'(lat), 64'd33);
        check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);
        @(posedge clk); #1;

        run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, "mult_m3x5", 0);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max", 5);
        repeat (40) @(posedge clk);
        #1 check("idle_after_ignored_start", 64'(busy), 64'd0);

        run_op(OP_DIVU, 32'd100,       32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7", 0);
        run_op(OP_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2", 0);
        run_op(OP_DIV,  32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, "div_7_m2", 0);
        run_op(OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, "div_minint_m1", 0);
        run_op(OP_DIVU, 32'd5,         32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, "divu_5_0", 0);
        run_op(OP_DIV,  32'hFFFFFFF8,  32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, "div_m8_0", 0);
        run_op(OP_DIVU, 32'd6,         32'd3,        32'd0,        32'd2,        1'b0, "divu_6_3", 0);
        run_op(OP_MULTU, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, "b2b_multu_3x4", 0);

        // MTHI then MTLO on consecutive cycles
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        @(posedge clk); #1;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo_unchanged", 64'(lo), 64'd12);
        check("mthi_busy", 64'(busy), 64'd0);
        op = OP_MTLO; a = 32'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_hilo", {hi, lo}, {32'h1234, 32'h5678});
        check("mtlo_busy", 64'(busy), 64'd0);
        check("mtlo_done", 64'(done), 64'd0);

        // Reset in the middle of a MULT aborts with no write and no done
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1 check("abort_still_idle", 64'(busy), 64'd0);

        // Accumulate ops
        start = 1'b1; op = OP_MTHI; a = 32'd0;
        @(posedge clk); #1;
        op = OP_MTLO; a = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef MULDIV_ACC_EN
        run_op(OP_MADD, 32'd3,        32'd4,  32'd0, 32'd22, 1'b0, "madd_3x4", 0);
        run_op(OP_MSUB, 32'hFFFFFFFF, 32'd30, 32'd0, 32'd52, 1'b0, "msub_m1x30", 0);
`else
        start = 1'b1; op = OP_MADD; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("op6_noop_busy", 64'(busy), 64'd0);
        check("op6_noop_hilo", {hi, lo}, {32'd0, 32'd10});
        repeat (40) @(posedge clk);
        #1 check("op6_noop_hilo_later", {hi, lo}, {32'd0, 32'd10});
`endif
        repeat (3) @(posedge clk);
        #1 check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
